// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked, burst-capped sharing of one TX FIFO write port.
// Every output is registered; a grant holds until its packet ends, the burst cap is reached or the request is withdrawn.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 9,
    parameter int MAX_BURST = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          last,
    input  logic [NREQ*DATA_W-1:0]   data,
    output logic [NREQ-1:0]          ack,
    input  logic                     fifo_full,
    output logic                     fifo_wr,
    output logic [DATA_W-1:0]        fifo_data,
    output logic [2:0]               grant_id,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;
    state_t              state, state_n;
    logic [2:0]          last_winner, last_winner_n, grant_id_n, cand, pick;
    logic [7:0]          burst, burst_n;
    logic                last_cap, last_cap_n, fifo_wr_n, found;
    logic [NREQ-1:0]     ack_n;
    logic [DATA_W-1:0]   fifo_data_n;
    logic [7:0]          req_pad, last_pad;
    logic [DATA_W-1:0]   words [8];
    assign req_pad  = 8'(req);
    assign last_pad = 8'(last);
    // Pad the requester set to 8 entries so a 3-bit grant index always selects in range.
    for (genvar i = 0; i < 8; i++) begin : g_words
        if (i < NREQ) begin : g_real
            assign words[i] = data[i*DATA_W +: DATA_W];
        end else begin : g_pad
            assign words[i] = '0;
        end
    end
    always_comb begin
        state_n       = state;
        last_winner_n = last_winner;
        grant_id_n    = grant_id;
        burst_n       = burst;
        last_cap_n    = last_cap;
        fifo_wr_n     = 1'b0;
        ack_n         = '0;
        fifo_data_n   = fifo_data;
        found         = 1'b0;
        pick          = '0;
        cand          = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = 3'((int'(last_winner) + k) % NREQ);
            if (!found && req_pad[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        case (state)
            IDLE: begin
                if (found) begin
                    grant_id_n = pick;
                    burst_n    = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (!req_pad[grant_id]) begin
                    last_winner_n = grant_id;
                    state_n       = IDLE;
                end else if (!fifo_full) begin
                    fifo_wr_n   = 1'b1;
                    fifo_data_n = words[grant_id];
                    for (int i = 0; i < NREQ; i++) ack_n[i] = (3'(i) == grant_id);
                    last_cap_n  = last_pad[grant_id];
                    state_n     = WRITE;
                end
            end
            WRITE: begin
                burst_n = burst + 8'd1;
                if (last_cap || burst == 8'(MAX_BURST - 1)) begin
                    last_winner_n = grant_id;
                    state_n       = IDLE;
                end else begin
                    state_n = GRANT;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_winner <= 3'(NREQ - 1);
            grant_id    <= '0;
            burst       <= '0;
            last_cap    <= 1'b0;
            fifo_wr     <= 1'b0;
            ack         <= '0;
            fifo_data   <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            last_winner <= last_winner_n;
            grant_id    <= grant_id_n;
            burst       <= burst_n;
            last_cap    <= last_cap_n;
            fifo_wr     <= fifo_wr_n;
            ack         <= ack_n;
            fifo_data   <= fifo_data_n;
            busy        <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: queue-driven requesters plus a packet-level round-robin model scoring every FIFO write.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4, DW = 9, MB = 8;
    typedef struct packed {logic [2:0] id; logic [8:0] d;} wr_t;
    logic clk = 0, reset = 0, fifo_full = 0;
    logic [NREQ-1:0] req = '0, last = '0, ack, en = '1;
    logic [NREQ*DW-1:0] data = '0;
    logic fifo_wr, busy;
    logic [DW-1:0] fifo_data;
    logic [2:0] grant_id;
    int cyc = 0, passes = 0, total = 0;
    wr_t exq[$];
    wr_t e;
    int wr_ids[$], wr_dat[$], wr_cyc[$];
    logic [9:0] dq[NREQ][$];
    logic [9:0] mq[NREQ][$];

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(req), .last(last), .data(data), .ack(ack),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_data(fifo_data),
        .grant_id(grant_id), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, int got, int exp);
        total++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", n, got, exp);
    endtask

    // Scoreboard and requester drivers both act on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("ack_onehot", int'($onehot0(ack)), 1);
            chk("ack_vs_wr", int'(ack != 0), int'(fifo_wr));
            if (fifo_wr) begin
                chk("ack_is_grant", int'(ack), 1 << grant_id);
                wr_ids.push_back(int'(grant_id));
                wr_dat.push_back(int'(fifo_data));
                wr_cyc.push_back(cyc);
                if (exq.size() == 0) chk("unexpected_write", 0, 1);
                else begin
                    e = exq.pop_front();
                    chk("wr_id", int'(grant_id), int'(e.id));
                    chk("wr_data", int'(fifo_data), int'(e.d));
                end
            end
            for (int i = 0; i < NREQ; i++) if (ack[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        end
        for (int i = 0; i < NREQ; i++) begin
            req[i] = en[i] && dq[i].size() > 0;
            {last[i], data[i*DW +: DW]} = dq[i].size() > 0 ? dq[i][0] : 10'h0;
        end
    end

    task automatic load(int i, logic [9:0] w);
        dq[i].push_back(w);
        mq[i].push_back(w);
    endtask

    // Packet-level rules: pick next non-empty requester after the last winner,
    // take words until its packet ends or MB words have gone, then rotate.
    task automatic model_run();
        int lw = NREQ - 1;
        forever begin
            int g = -1, n = 0;
            logic [9:0] w;
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && mq[(lw + k) % NREQ].size() > 0) g = (lw + k) % NREQ;
            if (g < 0) break;
            forever begin
                w = mq[g].pop_front();
                exq.push_back({3'(g), w[8:0]});
                n++;
                if (w[9] || n == MB || mq[g].size() == 0) break;
            end
            lw = g;
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < NREQ; i++) if (en[i]) s += dq[i].size();
        return s;
    endfunction

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 0;
        for (int i = 0; i < NREQ; i++) begin dq[i].delete(); mq[i].delete(); end
        exq.delete(); wr_ids.delete(); wr_dat.delete(); wr_cyc.delete();
        en = '1; fifo_full = 0;
        @(negedge clk); #2;
        chk("reset_outs", int'({ack, fifo_wr, fifo_data, grant_id, busy}), 0);
        reset = 1;
    endtask

    task automatic wait_done(string n, int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk); #2;
            if (exq.size() == 0 && !busy && pending() == 0) break;
        end
        chk({n, "_done"}, int'(k < budget), 1);
    endtask

    initial begin
        int c0, k;
        int fair[6] = '{1, 2, 3, 1, 2, 3};
        do_reset();
        // single requester, three-word packet
        load(0, {1'b0, 9'h041}); load(0, {1'b0, 9'h042}); load(0, {1'b1, 9'h143});
        model_run();
        @(negedge clk); #2;
        c0 = cyc;
        wait_done("single", 40);
        chk("single_count", wr_cyc.size(), 3);
        if (wr_cyc.size() == 3) begin
            chk("single_lat0", wr_cyc[0] - c0, 2);
            chk("single_lat1", wr_cyc[1] - c0, 4);
            chk("single_lat2", wr_cyc[2] - c0, 6);
            chk("single_last", wr_dat[2], 'h143);
        end
        chk("single_busy", int'(busy), 0);
        // fairness across three requesters
        do_reset();
        for (int i = 1; i < NREQ; i++) begin
            load(i, {1'b1, 9'(16 * i)});
            load(i, {1'b1, 9'(16 * i + 1)});
        end
        model_run();
        wait_done("fair", 60);
        chk("fair_count", wr_ids.size(), 6);
        if (wr_ids.size() == 6) for (int j = 0; j < 6; j++) chk("fair_order", wr_ids[j], fair[j]);
        // burst cap splits a 20-word packet
        do_reset();
        for (int w = 0; w < 20; w++) load(0, {w == 19, 9'(w)});
        for (int w = 0; w < 3; w++) load(2, {w == 2, 9'(9'h100 + w)});
        model_run();
        wait_done("burst", 200);
        chk("burst_count", wr_ids.size(), 23);
        if (wr_ids.size() == 23) begin
            chk("burst_w7", wr_ids[7], 0);
            chk("burst_w8", wr_ids[8], 2);
            chk("burst_w10", wr_ids[10], 2);
            chk("burst_w11", wr_ids[11], 0);
            chk("burst_d11", wr_dat[11], 8);
            chk("burst_d18", wr_dat[18], 15);
            chk("burst_d19", wr_dat[19], 16);
        end
        // backpressure during GRANT
        do_reset();
        fifo_full = 1;
        load(1, {1'b1, 9'h0AB});
        model_run();
        for (k = 0; k < 10; k++) begin @(negedge clk); #2; if (busy) break; end
        chk("bp_granted", int'(busy), 1);
        repeat (10) begin @(negedge clk); #2; chk("bp_nowr", int'({fifo_wr, ack}), 0); end
        fifo_full = 0;
        @(negedge clk); #2;
        chk("bp_wr", int'(fifo_wr), 1);
        chk("bp_data", int'(fifo_data), 'h0AB);
        wait_done("bp", 20);
        // withdrawal while granted
        do_reset();
        fifo_full = 1;
        load(1, {1'b1, 9'h011}); load(2, {1'b1, 9'h122});
        exq.push_back({3'd2, 9'h122});
        for (k = 0; k < 10; k++) begin @(negedge clk); #2; if (busy && grant_id == 1) break; end
        chk("wd_granted1", int'(k < 10), 1);
        en[1] = 0;
        @(negedge clk); #2;
        @(negedge clk); #2;
        chk("wd_idle", int'(busy), 0);
        chk("wd_hold_id", int'(grant_id), 1);
        @(negedge clk); #2;
        chk("wd_next_busy", int'(busy), 1);
        chk("wd_next_id", int'(grant_id), 2);
        fifo_full = 0;
        wait_done("wd", 20);
        // asynchronous reset during WRITE
        do_reset();
        load(0, {1'b1, 9'h155});
        exq.push_back({3'd0, 9'h155});
        for (k = 0; k < 10; k++) begin @(negedge clk); #2; if (fifo_wr) break; end
        chk("rst_in_write", int'(fifo_wr), 1);
        reset = 0;
        #1;
        chk("rst_async", int'({fifo_wr, ack, busy}), 0);
        do_reset();
        load(0, {1'b1, 9'h0F0}); load(3, {1'b1, 9'h033});
        model_run();
        wait_done("rst", 30);
        chk("rst_count", wr_ids.size(), 2);
        if (wr_ids.size() == 2) begin
            chk("rst_first", wr_ids[0], 0);
            chk("rst_second", wr_ids[1], 3);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO write port among NREQ on-chip requesters, for example a CPU bridge, a debug monitor and a DMA stream.
- Each requester presents 9-bit words, which is the TX FIFO/transmitter word width, with a packet "last" flag.
- Grants are round-robin with packet lock and a burst cap, so no requester can starve the others.
- Sits between the requesters and the TX FIFO DataIn/write/full interface, producing one-cycle write pulses.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DATA_W, 9, word width; matches the TX FIFO data width.
- MAX_BURST, 8, maximum words per grant before forced rotation (1..255).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester word-valid; held until the matching ack pulse.
- last  in  NREQ  per-requester end-of-packet flag, qualified with req.
- data  in  NREQ*DATA_W  requester words; requester i uses bits [i*DATA_W +: DATA_W].
- ack  out  NREQ  one-cycle pulse: the word of requester i was written to the FIFO.
- fifo_full  in  1  TX FIFO full status.
- fifo_wr  out  1  one-cycle write strobe to the TX FIFO.
- fifo_data  out  DATA_W  word to the TX FIFO; valid while fifo_wr=1.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  1 when state is not IDLE.

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE; ack, fifo_wr, fifo_data, grant_id, busy all 0.
- Internal last_winner=NREQ-1, so requester 0 has first priority.
- Burst counter is 0.

All outputs are registered.

State machine:
- IDLE
  - If any req bit is set, select the first set bit searching from last_winner+1 upward, wrapping modulo NREQ.
  - Latch it into grant_id, clear the burst counter, go to GRANT.
  - Arbitration takes exactly one cycle.
- GRANT
  - req[g]=0: release. last_winner<=g, go to IDLE. This covers a requester that withdraws its request.
  - req[g]=1 and fifo_full=1: stay in GRANT with no write. Ungranted requests are ignored; there is no timeout.
  - req[g]=1 and fifo_full=0: on this edge fifo_wr<=1, fifo_data<=data[g], ack[g]<=1, capture last[g], go to WRITE.
- WRITE (exactly one cycle)
  - fifo_wr and ack return to 0 on the next edge; the burst counter increments.
  - If the captured last=1, or the burst counter reaches MAX_BURST-1 before incrementing: last_winner<=g, go to IDLE.
  - Otherwise return to GRANT.
  - req and data are ignored in WRITE. This gives the requester one cycle after ack to present its next word or drop req.
  - It also lets fifo_full reflect the write just made.

Timing and fairness:
- Peak throughput is 1 word per 2 cycles.
- Latency from req (IDLE, FIFO not full) to the fifo_wr rising edge is 2 cycles.
- Each ack corresponds to exactly one fifo_wr. At most one ack bit is ever set.
- A requester that loses a grant at the burst cap keeps req asserted and re-enters round-robin. The remaining words of its packet continue on its next grant, so the cap can split a packet.
- A new req arriving while another requester holds the grant waits; it is not pre-empted.
- A single requester asserting req continuously re-wins after each release, with one IDLE cycle between grants.

Boundary conditions:
- Round-robin wraps from NREQ-1 to 0.
- Asynchronous reset mid-WRITE clears fifo_wr immediately. No second write occurs and the word is treated as not written, since ack is cleared too.
- grant_id is held after release until the next grant.

Test Plan:
- Single requester: req[0]=1 with data 0x041, 0x042, 0x143 (last=1 on the third) -> fifo_wr pulses every 2 cycles carrying 0x041, 0x042, 0x143. ack[0] pulses coincide with fifo_wr. Return to IDLE after the third word; busy=0.
- Fairness: req[1], req[2] and req[3] all asserted after reset, each sending single-word packets (last=1) -> grant order 1, 2, 3, 1, 2, 3. No ack overlap.
- Burst cap: MAX_BURST=8, requester 0 sends a 20-word packet while req[2] is asserted -> words 0-7 from requester 0, then requester 2's packet, then words 8-15 from requester 0.
- Backpressure: fifo_full=1 held for 10 cycles during GRANT -> no fifo_wr and no ack during those cycles. The first write occurs 1 cycle after fifo_full falls and carries the pending data unchanged.
- Withdrawal: requester 1 drops req while granted in GRANT -> no write, IDLE next cycle, last_winner=1. A pending req[2] is granted next.
- Reset: reset driven low while in WRITE -> fifo_wr=0, ack=0, busy=0 immediately. After release, requester 0 wins over requester 3 when both request.
